// File: rtl/fp_vec3_normalize_folded_pkg.sv
// Shared fixed-point types, arithmetic helpers and state encoding for the
// folded vec3 normalizer.
package fp_vec3_normalize_folded_pkg;

    localparam int WIDTH            = 32;
    localparam int NUM_WHOLE_DIGITS = 16;
    localparam int FRAC_BITS        = WIDTH - NUM_WHOLE_DIGITS;

    typedef logic signed [WIDTH-1:0]   fp_t;
    typedef logic signed [2*WIDTH-1:0] fp_wide_t;

    localparam fp_t FP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fp_t FP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SQX,
        ST_SQY,
        ST_SQZ,
        ST_CHK,
        ST_REQ,
        ST_WAIT,
        ST_SCX,
        ST_SCY,
        ST_SCZ,
        ST_DONE
    } vec3_state_t;

    // Full-precision product realigned to the fixed-point position.
    function automatic fp_wide_t fp_mul_wide(input fp_t a, input fp_t b);
        fp_wide_t prod;
        prod = fp_wide_t'(a) * fp_wide_t'(b);
        return prod >>> FRAC_BITS;
    endfunction

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        return fp_t'(fp_mul_wide(a, b));
    endfunction

    function automatic fp_t fp_sat(input fp_wide_t w);
        if (w > fp_wide_t'(FP_MAX)) return FP_MAX;
        if (w < fp_wide_t'(FP_MIN)) return FP_MIN;
        return fp_t'(w);
    endfunction

    function automatic fp_t fp_add_sat(input fp_t a, input fp_t b);
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1]) return sum[WIDTH] ? FP_MIN : FP_MAX;
        return fp_t'(sum[WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/fp_vec3_normalize_folded.sv
// Normalizes a signed fixed-point 3-vector using one shared multiplier and an
// external inverse-square-root unit reached over a valid/ready request port.
module fp_vec3_normalize_folded
    import fp_vec3_normalize_folded_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] isq_a_out,
    output logic                    isq_valid_out,
    input  logic                    isq_ready_in,
    input  logic signed [WIDTH-1:0] isq_res_in,
    input  logic                    isq_valid_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    valid_out,
    output logic                    zero_out,
    output logic                    err_out
);

    localparam int CNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    vec3_state_t      state, state_next;
    fp_t              x_r, y_r, z_r, acc, inv;
    logic [CNT_W-1:0] cnt;

    fp_t      mul_a, mul_b;
    fp_wide_t mul_p;
    fp_t      square, scaled;

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_SQX: begin mul_a = x_r; mul_b = x_r; end
            ST_SQY: begin mul_a = y_r; mul_b = y_r; end
            ST_SQZ: begin mul_a = z_r; mul_b = z_r; end
            ST_SCX: begin mul_a = x_r; mul_b = inv; end
            ST_SCY: begin mul_a = y_r; mul_b = inv; end
            ST_SCZ: begin mul_a = z_r; mul_b = inv; end
            default: ;
        endcase
    end

    // Squares are saturated at full precision so a large component can never
    // wrap into a negative partial sum.
    assign mul_p         = fp_mul_wide(mul_a, mul_b);
    assign square        = fp_sat(mul_p);
    assign scaled        = fp_t'(mul_p);
    assign isq_valid_out = (state == ST_REQ);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (valid_in) state_next = ST_SQX;
            ST_SQX:  state_next = ST_SQY;
            ST_SQY:  state_next = ST_SQZ;
            ST_SQZ:  state_next = ST_CHK;
            ST_CHK:  state_next = (acc == '0) ? ST_DONE : ST_REQ;
            ST_REQ:  if (isq_ready_in) state_next = ST_WAIT;
            ST_WAIT: begin
                if (isq_valid_in)         state_next = ST_SCX;
                else if (cnt == CNT_LAST) state_next = ST_DONE;
            end
            ST_SCX:  state_next = ST_SCY;
            ST_SCY:  state_next = ST_SCZ;
            ST_SCZ:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            acc       <= '0;
            inv       <= '0;
            cnt       <= '0;
            isq_a_out <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
            zero_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            valid_out <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        x_r       <= x_in;
                        y_r       <= y_in;
                        z_r       <= z_in;
                        acc       <= '0;
                        ready_out <= 1'b0;
                    end
                end
                ST_SQX, ST_SQY, ST_SQZ: acc <= fp_add_sat(acc, square);
                ST_CHK: begin
                    if (acc == '0) begin
                        x_out    <= '0;
                        y_out    <= '0;
                        z_out    <= '0;
                        zero_out <= 1'b1;
                        err_out  <= 1'b0;
                    end else begin
                        isq_a_out <= acc;
                    end
                end
                ST_REQ: if (isq_ready_in) cnt <= '0;
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (isq_valid_in) begin
                        inv <= isq_res_in;
                    end else if (cnt == CNT_LAST) begin
                        x_out    <= '0;
                        y_out    <= '0;
                        z_out    <= '0;
                        zero_out <= 1'b0;
                        err_out  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SCX: x_out <= scaled;
                ST_SCY: y_out <= scaled;
                ST_SCZ: begin
                    z_out    <= scaled;
                    zero_out <= 1'b0;
                    err_out  <= 1'b0;
                end
                ST_DONE: ready_out <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_vec3_normalize_folded.sv
// Directed bench for fp_vec3_normalize_folded with a behavioural inverse-sqrt
// responder (configurable latency, request stall and no-answer modes).
module tb_fp_vec3_normalize_folded;

    typedef struct {
        logic signed [31:0] x, y, z;
        logic signed [31:0] ex, ey, ez;
        bit                 ezero, eerr;
        int                 lat;
        int                 nreq;
        logic [31:0]        ea;
    } vec_t;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic               valid_in;
    logic signed [31:0] x_in, y_in, z_in;
    logic               ready_out;
    logic [31:0]        isq_a_out;
    logic               isq_valid_out;
    logic               isq_ready_in;
    logic signed [31:0] isq_res_in;
    logic               isq_valid_in;
    logic signed [31:0] x_out, y_out, z_out;
    logic               valid_out, zero_out, err_out;

    int          checks = 0;
    int          errors = 0;
    int          req_count = 0;
    int          stall_seen = 0;
    int          done_count = 0;
    logic [31:0] last_a = '0;
    int          resp_latency = 2;
    bit          never_answer = 1'b0;
    int          stall_req = 0;

    fp_vec3_normalize_folded #(.WAIT_TIMEOUT(64)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .valid_in      (valid_in),
        .x_in          (x_in),
        .y_in          (y_in),
        .z_in          (z_in),
        .ready_out     (ready_out),
        .isq_a_out     (isq_a_out),
        .isq_valid_out (isq_valid_out),
        .isq_ready_in  (isq_ready_in),
        .isq_res_in    (isq_res_in),
        .isq_valid_in  (isq_valid_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .z_out         (z_out),
        .valid_out     (valid_out),
        .zero_out      (zero_out),
        .err_out       (err_out)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic logic [31:0] model_isqrt(input logic [31:0] a);
        real r;
        if (a == 32'd0) return 32'h7fff_ffff;
        r = $itor(a) / 65536.0;
        return 32'($rtoi(65536.0 / $sqrt(r)));
    endfunction

    // Behavioural inverse-sqrt unit; drives its outputs on the falling edge.
    initial begin : responder
        int          stall_left;
        bit          stall_done;
        bit          pending;
        int          rcnt;
        logic [31:0] rval;
        stall_left = 0; stall_done = 1'b0; pending = 1'b0; rcnt = 0; rval = '0;
        isq_ready_in = 1'b1; isq_valid_in = 1'b0; isq_res_in = '0;
        forever begin
            @(negedge clk_in);
            isq_valid_in = 1'b0;
            if (pending) begin
                if (rcnt == 0) begin
                    isq_valid_in = 1'b1;
                    isq_res_in   = rval;
                    pending      = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (stall_req == 0) stall_done = 1'b0;
            if (!stall_done && stall_req > 0 && isq_valid_out) begin
                stall_left = stall_req;
                stall_done = 1'b1;
                stall_seen = 0;
            end
            if (stall_left > 0) begin
                isq_ready_in = 1'b0;
                if (isq_valid_out) stall_seen++;
                stall_left--;
            end else begin
                isq_ready_in = 1'b1;
            end
            if (isq_valid_out && isq_ready_in) begin
                req_count++;
                last_a = isq_a_out;
                if (!never_answer) begin
                    pending = 1'b1;
                    rcnt    = resp_latency;
                    rval    = model_isqrt(isq_a_out);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (valid_out) done_count++;
    end

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic start_op(input logic signed [31:0] x, input logic signed [31:0] y,
                            input logic signed [31:0] z);
        int n;
        n = 0;
        while (!ready_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!ready_out) check("ready_wait", longint'(ready_out), 1, 0);
        x_in = x; y_in = y; z_in = z;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!valid_out && cycles < 300);
        if (!valid_out) check("done_timeout", longint'(valid_out), 1, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cyc, r0;
        r0 = req_count;
        start_op(v.x, v.y, v.z);
        wait_done(cyc);
        check({tag, ".lat"},  cyc, v.lat, 0);
        check({tag, ".x"},    longint'(x_out), longint'(v.ex), 64);
        check({tag, ".y"},    longint'(y_out), longint'(v.ey), 64);
        check({tag, ".z"},    longint'(z_out), longint'(v.ez), 64);
        check({tag, ".zero"}, longint'(zero_out), longint'(v.ezero), 0);
        check({tag, ".err"},  longint'(err_out), longint'(v.eerr), 0);
        check({tag, ".nreq"}, req_count - r0, v.nreq, 0);
        if (v.nreq > 0) check({tag, ".isq_a"}, longint'(last_a), longint'(v.ea), 0);
        @(negedge clk_in);
        check({tag, ".pulse"}, longint'(valid_out), 0, 0);
    endtask

    initial begin : main
        vec_t tbl[7];
        vec_t v;
        int   cyc, d0, r0, n;

        // Q16.16: 0x6000=0.375, 0x8000=0.5, 0x10000=1.0
        tbl[0] = '{32'sh6000, 0, 32'sh8000, 39322, 0, 52429, 1'b0, 1'b0, 12, 1, 32'h6400};
        tbl[1] = '{-32'sh6000, -32'sh8000, 0, -39322, -52429, 0, 1'b0, 1'b0, 12, 1, 32'h6400};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 5, 0, 32'h0};
        tbl[3] = '{0, 32'sh8000, 0, 0, 65536, 0, 1'b0, 1'b0, 12, 1, 32'h4000};
        // 200^2 overflows the range: sum saturates, 200/sqrt(32768) ~ 1.1049
        tbl[4] = '{32'sd13107200, -32'sd13107200, 0, 72408, -72408, 0, 1'b0, 1'b0, 12, 1, 32'h7fff_ffff};
        tbl[5] = '{0, 0, -32'sh10000, 0, 0, -65536, 1'b0, 1'b0, 12, 1, 32'h10000};
        tbl[6] = '{32'sh100, 0, 0, 65536, 0, 0, 1'b0, 1'b0, 12, 1, 32'h1};

        rst_n_in = 1'b0; valid_in = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst.ready", longint'(ready_out), 1, 0);
        check("rst.valid", longint'(valid_out), 0, 0);
        check("rst.zero",  longint'(zero_out), 0, 0);
        check("rst.err",   longint'(err_out), 0, 0);
        check("rst.isq_v", longint'(isq_valid_out), 0, 0);
        check("rst.isq_a", longint'(isq_a_out), 0, 0);
        check("rst.x",     longint'(x_out), 0, 0);
        check("rst.z",     longint'(z_out), 0, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 7; i++) run_vec($sformatf("row%0d", i), tbl[i]);

        // Request stalled for 7 cycles, responder answers in the first WAIT cycle.
        stall_req = 7; resp_latency = 0;
        v = '{-32'sh10000, 0, 0, -65536, 0, 0, 1'b0, 1'b0, 17, 1, 32'h10000};
        run_vec("stall", v);
        check("stall.valid_held", stall_seen, 7, 0);
        stall_req = 0; resp_latency = 2;

        // No answer: 64 cycles in WAIT then an error completion.
        never_answer = 1'b1;
        v = '{32'sh6000, 0, 32'sh8000, 0, 0, 0, 1'b0, 1'b1, 70, 1, 32'h6400};
        run_vec("timeout", v);
        never_answer = 1'b0;
        v = '{0, 32'sh10000, 0, 0, 65536, 0, 1'b0, 1'b0, 12, 1, 32'h10000};
        run_vec("after_to", v);

        // Back-to-back accept on the valid_out cycle, then valid_in while busy.
        d0 = done_count;
        start_op(tbl[0].x, tbl[0].y, tbl[0].z);
        wait_done(cyc);
        check("b2b.x1", longint'(x_out), 39322, 64);
        check("b2b.z1", longint'(z_out), 52429, 64);
        check("b2b.ready", longint'(ready_out), 1, 0);
        x_in = '0; y_in = '0; z_in = -32'sh10000;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        x_in = 32'sh100; y_in = '0; z_in = '0;
        valid_in = 1'b1;
        repeat (4) @(negedge clk_in);
        valid_in = 1'b0;
        wait_done(cyc);
        check("b2b.x2", longint'(x_out), 0, 64);
        check("b2b.z2", longint'(z_out), -65536, 64);
        repeat (30) @(negedge clk_in);
        check("b2b.completions", done_count - d0, 2, 0);

        // Asynchronous reset while waiting for a slow response.
        resp_latency = 20;
        r0 = req_count;
        start_op(tbl[0].x, tbl[0].y, tbl[0].z);
        n = 0;
        while (req_count == r0 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("arst.req_seen", req_count - r0, 1, 0);
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst.ready", longint'(ready_out), 1, 0);
        check("arst.valid", longint'(valid_out), 0, 0);
        check("arst.isq_v", longint'(isq_valid_out), 0, 0);
        check("arst.x",     longint'(x_out), 0, 0);
        check("arst.z",     longint'(z_out), 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        d0 = done_count;
        repeat (30) @(negedge clk_in);
        check("arst.no_done", done_count - d0, 0, 0);
        resp_latency = 2;
        tbl[3].lat = 12;
        run_vec("arst.next", tbl[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
